// File: rtl/ghash_seq_pkg.sv
// ghash_seq_pkg -- shared definitions for the sequential GHASH engine.
//   BLK_W       : GHASH block width (128)
//   MUL_CYCLES  : cycles taken by one bit-serial GF(2^128) multiply (128)
//   GF_R        : GCM reduction constant, E1 followed by 120 zero bits
//   state_t     : controller state encoding
//   gf_shift_v  : one right-shift step of the multiplicand with reduction
// Feature macro: GHASH_SEQ_LEN_BLOCK_EN (see ghash_seq.sv).
package ghash_seq_pkg;

   localparam int unsigned BLK_W      = 128;
   localparam int unsigned MUL_CYCLES = 128;
   localparam logic [BLK_W-1:0] GF_R  = {8'hE1, 120'd0};

   typedef enum logic [2:0] {
      IDLE,
      WAIT_BLK,
      MUL,
      LEN,
      MUL_LEN,
      DONE
   } state_t;

   // Bit 0 of a GCM block is the vector MSB, so "multiply by x" is a
   // right shift; the bit falling out of vector bit 0 folds back as GF_R.
   function automatic logic [BLK_W-1:0] gf_shift_v(input logic [BLK_W-1:0] v);
      return v[0] ? ((v >> 1) ^ GF_R) : (v >> 1);
   endfunction

endpackage

// File: rtl/ghash_seq_gf128_mul_serial.sv
// gf128_mul_serial -- bit-serial GF(2^128) multiplier, GCM convention.
// Ports:
//   iClk, iRst_n : clock, synchronous active-low reset
//   i_start      : one-cycle pulse; i_x and i_h are captured on this edge
//   i_x          : operand X (bit 0 = MSB)
//   i_h          : operand H (bit 0 = MSB)
//   o_z          : product X*H, valid while o_done is high and held after
//   o_done       : one-cycle pulse exactly MUL_CYCLES cycles after i_start
module gf128_mul_serial
   import ghash_seq_pkg::*;
(
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic             i_start,
   input  logic [BLK_W-1:0] i_x,
   input  logic [BLK_W-1:0] i_h,
   output logic [BLK_W-1:0] o_z,
   output logic             o_done
);

   localparam int unsigned CNT_W = $clog2(MUL_CYCLES);

   logic [BLK_W-1:0] r_z;
   logic [BLK_W-1:0] r_v;
   logic [BLK_W-1:0] r_x;
   logic [CNT_W-1:0] r_cnt;
   logic             r_run;
   logic             r_done;

   // The first X bit is consumed on the start edge itself, so the last of
   // the 128 bits lands on the edge that raises r_done, 128 cycles after
   // the start cycle, and the product is ready for the caller's next edge.
   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         r_z    <= '0;
         r_v    <= '0;
         r_x    <= '0;
         r_cnt  <= '0;
         r_run  <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_start) begin
            r_z   <= i_x[BLK_W-1] ? i_h : '0;
            r_v   <= gf_shift_v(i_h);
            r_x   <= i_x << 1;
            r_cnt <= CNT_W'(1);
            r_run <= 1'b1;
         end else if (r_run) begin
            if (r_x[BLK_W-1]) begin
               r_z <= r_z ^ r_v;
            end
            r_v   <= gf_shift_v(r_v);
            r_x   <= r_x << 1;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(MUL_CYCLES - 1)) begin
               r_run  <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign o_z    = r_z;
   assign o_done = r_done;

endmodule

// File: rtl/ghash_seq.sv
// ghash_seq -- sequential GHASH engine (GCM authentication hash).
// Computes Y = GHASH_H(blocks [|| len block]) one block per 129 cycles
// using the bit-serial multiplier gf128_mul_serial.
// Ports:
//   iClk, iRst_n       : clock, synchronous active-low reset
//   iStart, iNo_data   : begin a computation (optionally with no data blocks)
//   iHashkey           : H, latched on iStart
//   iData, iData_valid, iData_last, oData_ready : block stream handshake
//   iLen_aad, iLen_ct  : bit lengths forming the final length block
//   oTag, oTag_valid   : result and its one-cycle strobe; oTag holds
//   oBusy              : high whenever not IDLE
// Macro GHASH_SEQ_LEN_BLOCK_EN: when defined the engine appends the
// {iLen_aad, iLen_ct} block itself (LEN / MUL_LEN states). When undefined
// the length inputs are unused and the caller sends the length block as
// the last data block.
module ghash_seq
   import ghash_seq_pkg::*;
(
   input  logic         iClk,
   input  logic         iRst_n,
   input  logic         iStart,
   input  logic [127:0] iHashkey,
   input  logic         iNo_data,
   input  logic [127:0] iData,
   input  logic         iData_valid,
   input  logic         iData_last,
   output logic         oData_ready,
   input  logic [63:0]  iLen_aad,
   input  logic [63:0]  iLen_ct,
   output logic [127:0] oTag,
   output logic         oTag_valid,
   output logic         oBusy
);

   state_t           r_state;
   logic [BLK_W-1:0] r_h;
   logic [BLK_W-1:0] r_y;
   logic             r_last;
   logic [BLK_W-1:0] r_tag;
   logic             r_tag_valid;
   logic             r_ready;
   logic             r_busy;

   logic             w_hs;
   logic             w_mul_start;
   logic [BLK_W-1:0] w_mul_x;
   logic [BLK_W-1:0] w_mul_z;
   logic             w_mul_done;

   assign w_hs = (r_state == WAIT_BLK) && iData_valid;

   // The multiplier is started combinationally in the handshake (or LEN)
   // cycle so its first bit step coincides with the state change edge.
   always_comb begin
      w_mul_start = w_hs;
      w_mul_x     = r_y ^ iData;
`ifdef GHASH_SEQ_LEN_BLOCK_EN
      if (r_state == LEN) begin
         w_mul_start = 1'b1;
         w_mul_x     = r_y ^ {iLen_aad, iLen_ct};
      end
`endif
   end

`ifndef GHASH_SEQ_LEN_BLOCK_EN
   logic w_unused_len;
   assign w_unused_len = ^{iLen_aad, iLen_ct};
`endif

   gf128_mul_serial u_mul (
      .iClk    (iClk),
      .iRst_n  (iRst_n),
      .i_start (w_mul_start),
      .i_x     (w_mul_x),
      .i_h     (r_h),
      .o_z     (w_mul_z),
      .o_done  (w_mul_done)
   );

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         r_state     <= IDLE;
         r_h         <= '0;
         r_y         <= '0;
         r_last      <= 1'b0;
         r_tag       <= '0;
         r_tag_valid <= 1'b0;
         r_ready     <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_tag_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (iStart) begin
                  r_h    <= iHashkey;
                  r_y    <= '0;
                  r_busy <= 1'b1;
                  if (iNo_data) begin
`ifdef GHASH_SEQ_LEN_BLOCK_EN
                     r_state <= LEN;
`else
                     r_state     <= DONE;
                     r_tag       <= '0;
                     r_tag_valid <= 1'b1;
`endif
                  end else begin
                     r_state <= WAIT_BLK;
                     r_ready <= 1'b1;
                  end
               end
            end
            WAIT_BLK: begin
               if (iData_valid) begin
                  r_last  <= iData_last;
                  r_ready <= 1'b0;
                  r_state <= MUL;
               end
            end
            MUL: begin
               if (w_mul_done) begin
                  r_y <= w_mul_z;
                  if (r_last) begin
`ifdef GHASH_SEQ_LEN_BLOCK_EN
                     r_state <= LEN;
`else
                     r_state     <= DONE;
                     r_tag       <= w_mul_z;
                     r_tag_valid <= 1'b1;
`endif
                  end else begin
                     r_state <= WAIT_BLK;
                     r_ready <= 1'b1;
                  end
               end
            end
`ifdef GHASH_SEQ_LEN_BLOCK_EN
            LEN: begin
               r_state <= MUL_LEN;
            end
            MUL_LEN: begin
               if (w_mul_done) begin
                  r_y         <= w_mul_z;
                  r_tag       <= w_mul_z;
                  r_tag_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
`endif
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_ready <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign oData_ready = r_ready;
   assign oBusy       = r_busy;
   assign oTag        = r_tag;
   assign oTag_valid  = r_tag_valid;

endmodule

// File: tb/tb_ghash_seq.sv
// tb_ghash_seq -- self-checking bench for ghash_seq. Expected tags are
// queued when a computation is started and checked by a strobe monitor.
// Works with GHASH_SEQ_LEN_BLOCK_EN either defined or undefined.
module tb_ghash_seq;

   localparam logic [127:0] H_TC    = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam logic [127:0] C_TC    = 128'h0388dace60b6a392f328c2b971b2fe78;
   localparam logic [127:0] T_TC    = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
   localparam logic [127:0] LEN_BLK = {64'd0, 64'd128};
`ifdef GHASH_SEQ_LEN_BLOCK_EN
   localparam bit LEN_EN = 1'b1;
`else
   localparam bit LEN_EN = 1'b0;
`endif

   logic         iClk        = 1'b0;
   logic         iRst_n      = 1'b0;
   logic         iStart      = 1'b0;
   logic [127:0] iHashkey    = '0;
   logic         iNo_data    = 1'b0;
   logic [127:0] iData       = '0;
   logic         iData_valid = 1'b0;
   logic         iData_last  = 1'b0;
   logic         oData_ready;
   logic [63:0]  iLen_aad    = '0;
   logic [63:0]  iLen_ct     = '0;
   logic [127:0] oTag;
   logic         oTag_valid;
   logic         oBusy;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int strobe_cnt  = 0;
   int strobe_cyc  = 0;
   logic [127:0] exp_q[$];
   logic [127:0] mon_exp;

   ghash_seq dut (
      .iClk        (iClk),
      .iRst_n      (iRst_n),
      .iStart      (iStart),
      .iHashkey    (iHashkey),
      .iNo_data    (iNo_data),
      .iData       (iData),
      .iData_valid (iData_valid),
      .iData_last  (iData_last),
      .oData_ready (oData_ready),
      .iLen_aad    (iLen_aad),
      .iLen_ct     (iLen_ct),
      .oTag        (oTag),
      .oTag_valid  (oTag_valid),
      .oBusy       (oBusy)
   );

   always #5 iClk = ~iClk;
   always @(posedge iClk) cyc <= cyc + 1;

   // Result monitor: every strobe must match the oldest queued expectation.
   always @(negedge iClk) begin
      if (oTag_valid === 1'b1) begin
         strobe_cnt = strobe_cnt + 1;
         strobe_cyc = cyc;
         vectors    = vectors + 1;
         if (exp_q.size() == 0) begin
            miscompares = miscompares + 1;
            $display("FAIL unexpected_strobe: got tag %h, required no strobe", oTag);
         end else begin
            mon_exp = exp_q.pop_front();
            if (oTag !== mon_exp) begin
               miscompares = miscompares + 1;
               $display("FAIL tag: got %h, required %h", oTag, mon_exp);
            end
         end
      end
   end

   // Reference multiply: reflect to polynomial bit order, carry-less
   // multiply, reduce by x^128 + x^7 + x^2 + x + 1, reflect back.
   function automatic logic [127:0] refl(input logic [127:0] v);
      logic [127:0] r;
      for (int i = 0; i < 128; i++) r[i] = v[127-i];
      return r;
   endfunction

   function automatic logic [127:0] model_mul(input logic [127:0] a, input logic [127:0] b);
      logic [127:0] pa;
      logic [127:0] pb;
      logic [254:0] c;
      pa = refl(a);
      pb = refl(b);
      c  = '0;
      for (int i = 0; i < 128; i++)
         if (pa[i]) c = c ^ ({127'd0, pb} << i);
      for (int i = 254; i >= 128; i--) begin
         if (c[i]) begin
            c[i]     = 1'b0;
            c[i-121] = ~c[i-121];
            c[i-126] = ~c[i-126];
            c[i-127] = ~c[i-127];
            c[i-128] = ~c[i-128];
         end
      end
      return refl(c[127:0]);
   endfunction

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic do_start(input logic [127:0] h, input logic nd,
                           input logic [63:0] la, input logic [63:0] lc,
                           output int sc);
      iHashkey = h;
      iNo_data = nd;
      iLen_aad = la;
      iLen_ct  = lc;
      iStart   = 1'b1;
      sc       = cyc;
      tick();
      iStart   = 1'b0;
      iNo_data = 1'b0;
   endtask

   task automatic send_block(input logic [127:0] d, input logic last, output int hs);
      iData       = d;
      iData_last  = last;
      iData_valid = 1'b1;
      hs          = -1;
      for (int i = 0; i < 400; i++) begin
         if (oData_ready === 1'b1) begin
            tick();
            hs = cyc;
            break;
         end
         tick();
      end
      iData_valid = 1'b0;
      iData_last  = 1'b0;
      if (hs < 0) begin
         vectors     = vectors + 1;
         miscompares = miscompares + 1;
         $display("FAIL ready_timeout: got no oData_ready in 400 cycles, required handshake");
      end
   endtask

   task automatic wait_result(input int budget, input string name);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
      if (exp_q.size() != 0) begin
         vectors     = vectors + 1;
         miscompares = miscompares + 1;
         $display("FAIL %s_timeout: got %0d results outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      iRst_n = 1'b0;
      repeat (3) tick();
      vectors++; if (oData_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b, required 0", oData_ready); end
      vectors++; if (oBusy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b, required 0", oBusy); end
      vectors++; if (oTag_valid !== 1'b0) begin miscompares++; $display("FAIL rst_tag_valid: got %b, required 0", oTag_valid); end
      vectors++; if (oTag !== 128'd0) begin miscompares++; $display("FAIL rst_tag: got %h, required 0", oTag); end
      iRst_n = 1'b1;
      repeat (2) tick();
      vectors++; if (oBusy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b, required 0", oBusy); end
   endtask

   task automatic test_zero_length();
      int sc;
      int s0;
      s0 = strobe_cnt;
      exp_q.push_back(128'd0);
      do_start(H_TC, 1'b1, 64'd0, 64'd0, sc);
      wait_result(400, "zero_len");
      repeat (3) tick();
      vectors++;
      if (strobe_cyc - sc != (LEN_EN ? 130 : 1)) begin
         miscompares++;
         $display("FAIL zero_len_latency: got %0d, required %0d", strobe_cyc - sc, LEN_EN ? 130 : 1);
      end
      vectors++;
      if (strobe_cnt - s0 != 1) begin
         miscompares++;
         $display("FAIL zero_len_strobes: got %0d, required 1", strobe_cnt - s0);
      end
      vectors++; if (oBusy !== 1'b0) begin miscompares++; $display("FAIL zero_len_idle: got busy %b, required 0", oBusy); end
   endtask

   task automatic test_single_block();
      int sc;
      int hs;
      exp_q.push_back(T_TC);
      do_start(H_TC, 1'b0, 64'd0, 64'd128, sc);
      vectors++; if (oBusy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b, required 1", oBusy); end
      send_block(C_TC, LEN_EN, hs);
      if (!LEN_EN) send_block(LEN_BLK, 1'b1, hs);
      wait_result(600, "single");
      vectors++;
      if (strobe_cyc - hs != (LEN_EN ? 257 : 128)) begin
         miscompares++;
         $display("FAIL last_to_tag_latency: got %0d, required %0d", strobe_cyc - hs, LEN_EN ? 257 : 128);
      end
      repeat (5) tick();
      vectors++; if (oTag !== T_TC) begin miscompares++; $display("FAIL tag_hold: got %h, required %h", oTag, T_TC); end
      vectors++; if (oTag_valid !== 1'b0) begin miscompares++; $display("FAIL strobe_width: got %b, required 0", oTag_valid); end
   endtask

   task automatic test_back_to_back();
      logic [127:0] b[3];
      logic [127:0] h;
      logic [127:0] y;
      int hs[3];
      int n;
      int sc;
      bit got;
      h    = {$urandom, $urandom, $urandom, $urandom};
      b[0] = {$urandom, $urandom, $urandom, $urandom};
      b[1] = {$urandom, $urandom, $urandom, $urandom};
      b[2] = {64'd128, 64'd128};
      y    = '0;
      for (int k = 0; k < 3; k++) y = model_mul(y ^ b[k], h);
      exp_q.push_back(y);
      n = LEN_EN ? 2 : 3;
      do_start(h, 1'b0, 64'd128, 64'd128, sc);
      iData_valid = 1'b1;
      for (int k = 0; k < n; k++) begin
         iData      = b[k];
         iData_last = (k == n - 1);
         got        = 1'b0;
         for (int i = 0; i < 400; i++) begin
            if (oData_ready === 1'b1) begin
               tick();
               got = 1'b1;
               break;
            end
            tick();
         end
         if (!got) begin
            vectors++; miscompares++;
            $display("FAIL b2b_ready_timeout: got no ready for block %0d, required handshake", k);
            break;
         end
         hs[k] = cyc;
         if (k > 0) begin
            vectors++;
            if (hs[k] - hs[k-1] != 129) begin
               miscompares++;
               $display("FAIL ready_spacing: got %0d, required 129", hs[k] - hs[k-1]);
            end
         end
      end
      iData_valid = 1'b0;
      iData_last  = 1'b0;
      wait_result(700, "b2b");
   endtask

   task automatic test_ignore_during_mul();
      int sc;
      int hs;
      bit saw_ready;
      exp_q.push_back(T_TC);
      do_start(H_TC, 1'b0, 64'd0, 64'd128, sc);
      send_block(C_TC, LEN_EN, hs);
      repeat (10) tick();
      iHashkey    = ~H_TC;
      iNo_data    = 1'b1;
      iStart      = 1'b1;
      iData       = 128'hdeadbeef_00000000_cafef00d_12345678;
      iData_last  = 1'b1;
      iData_valid = 1'b1;
      tick();
      iStart    = 1'b0;
      iNo_data  = 1'b0;
      saw_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (oData_ready !== 1'b0) saw_ready = 1'b1;
         tick();
      end
      iData_valid = 1'b0;
      iData_last  = 1'b0;
      iHashkey    = H_TC;
      vectors++; if (saw_ready) begin miscompares++; $display("FAIL ready_in_mul: got 1, required 0"); end
      vectors++; if (oBusy !== 1'b1) begin miscompares++; $display("FAIL busy_in_mul: got %b, required 1", oBusy); end
      if (!LEN_EN) send_block(LEN_BLK, 1'b1, hs);
      wait_result(600, "ignore");
   endtask

   task automatic test_reset_mid_mul();
      int sc;
      int hs;
      int s0;
      do_start(H_TC, 1'b0, 64'd0, 64'd128, sc);
      send_block(C_TC, LEN_EN, hs);
      repeat (59) tick();
      iRst_n = 1'b0;
      tick();
      vectors++; if (oBusy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b, required 0", oBusy); end
      vectors++; if (oData_ready !== 1'b0) begin miscompares++; $display("FAIL abort_ready: got %b, required 0", oData_ready); end
      vectors++; if (oTag !== 128'd0) begin miscompares++; $display("FAIL abort_tag: got %h, required 0", oTag); end
      iRst_n = 1'b1;
      s0 = strobe_cnt;
      repeat (300) tick();
      vectors++;
      if (strobe_cnt != s0) begin
         miscompares++;
         $display("FAIL abort_strobe: got %0d strobes, required 0", strobe_cnt - s0);
      end
      test_single_block();
   endtask

   initial begin
      test_reset();
      test_zero_length();
      test_single_block();
      test_back_to_back();
      test_ignore_during_mul();
      test_reset_mid_mul();
      repeat (5) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
